dr_sync_sink: RTL and testbench

// Clocked consumer for the dual-rail four-phase ("FP") result channel of the async Fibonacci core.

---
 rtl/dr_sync_sink.sv | 163 ++++++++++++++++
 tb/tb_dr_sync_sink.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_sync_sink.sv
// dr_sync_sink: clocked receiver for a dual-rail four-phase data channel.
// The completion and null detectors are synchronised into clk.
// The FSM returns the four-phase acknowledge to the producer.
// Each captured codeword is decoded to single-rail and queued in a small FIFO.
// The FIFO head is presented on a registered valid/ready stream.
module dr_sync_sink #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0][1:0]        in,
    output logic                         ack_o,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_NULL = 2'd2
    } state_t;

    // Per-pair views of the dual-rail bus.
    logic [WIDTH-1:0] pair_set;
    logic [WIDTH-1:0] pair_bad;
    logic [WIDTH-1:0] decoded;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair
        assign pair_set[gi] = in[gi][1] | in[gi][0];
        assign pair_bad[gi] = in[gi][1] & in[gi][0];
        assign decoded[gi]  = in[gi][1];
    end

    // These detectors are driven by the asynchronous bus. They are used only through the synchronisers.
    logic complete_raw;
    logic null_raw;
    assign complete_raw = &pair_set;
    assign null_raw     = ~|pair_set;

    logic [SYNC_STAGES-1:0] complete_sync_reg;
    logic [SYNC_STAGES-1:0] null_sync_reg;
    logic                   complete_s;
    logic                   null_s;

    assign complete_s = complete_sync_reg[SYNC_STAGES-1];
    assign null_s     = null_sync_reg[SYNC_STAGES-1];

    // Synchroniser chains for the completion and null detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            complete_sync_reg <= '0;
            null_sync_reg     <= '0;
        end else begin
            complete_sync_reg <= {complete_sync_reg[SYNC_STAGES-2:0], complete_raw};
            null_sync_reg     <= {null_sync_reg[SYNC_STAGES-2:0], null_raw};
        end
    end

    state_t                  state_reg;
    logic                    ack_reg;
    logic                    err_reg;
    logic [LVL_W-1:0]        level_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic                    m_valid_reg;
    logic [WIDTH-1:0]        m_data_reg;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic                    push;
    logic                    pop;
    logic [PTR_W-1:0]        rd_sel;
    logic [LVL_W-1:0]        level_after_pop;

    // Capture happens on the edge that leaves IDLE.
    // The full check uses the registered level, so a pop in the same cycle does not unblock that edge.
    assign push            = (state_reg == IDLE) && complete_s && (level_reg < LVL_W'(DEPTH));
    assign pop             = m_valid_reg && m_ready;
    assign rd_sel          = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    assign level_after_pop = level_reg - LVL_W'(pop);

    // Handshake FSM: IDLE captures and raises ack. CAPTURE lasts one cycle. WAIT_NULL drops ack once the bus returns to null.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (push) begin
                        state_reg <= CAPTURE;
                        ack_reg   <= 1'b1;
                        if (|pair_bad) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    state_reg <= WAIT_NULL;
                end
                WAIT_NULL: begin
                    if (null_s) begin
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage. There is no reset, so the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= decoded;
        end
    end

    // The pointers and occupancy are updated here.
    // The head register reads the entry that will be at the front once this edge's pop is taken into account.
    // A word pushed on this edge therefore appears at the head one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            m_valid_reg <= (level_after_pop != '0);
            m_data_reg  <= mem[rd_sel];
        end
    end

    assign ack_o   = ack_reg;
    assign err_o   = err_reg;
    assign level   = level_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;

endmodule

// File: tb/tb_dr_sync_sink.sv
// tb_dr_sync_sink: directed tests of dr_sync_sink.
// A queue-based reference model is checked every cycle, alongside hand-computed expectations.
module tb_dr_sync_sink;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [W-1:0][1:0]    din;
    logic                 ack_o;
    logic                 m_valid;
    logic                 m_ready;
    logic [W-1:0]         m_data;
    logic [2:0]           level;
    logic                 err_o;

    int checks = 0;
    int errors = 0;

    dr_sync_sink #(.WIDTH(W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (din),
        .ack_o   (ack_o),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Dual-rail encoding: a bit set in bad forces that pair to the illegal 2'b11.
    function automatic logic [W-1:0][1:0] dr(input logic [31:0] w, input logic [31:0] bad);
        logic [W-1:0][1:0] r;
        for (int b = 0; b < W; b++) begin
            if (bad[b])    r[b] = 2'b11;
            else if (w[b]) r[b] = 2'b10;
            else           r[b] = 2'b01;
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    bit          live  = 0;
    bit          mv    = 0;
    logic [31:0] md    = '0;
    bit          mack  = 0;
    bit          merr  = 0;
    bit          mbusy = 0;
    bit          mcool = 0;
    bit [SYNC-1:0] ch  = '0;
    bit [SYNC-1:0] nh  = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mv = 0; md = '0; mack = 0; merr = 0; mbusy = 0; mcool = 0;
                ch = '0; nh = '0;
                live = 1;
            end else begin
                bit cs, ns, pop, push, all_set, all_null, bad;
                logic [31:0] word;
                int n;
                cs = ch[SYNC-1];
                ns = nh[SYNC-1];
                pop = mv && m_ready;
                n = mq.size();
                push = 0;
                all_set = 1; all_null = 1; bad = 0;
                for (int b = 0; b < W; b++) begin
                    word[b] = din[b][1];
                    if (din[b] == 2'b00) all_set = 0;
                    else                 all_null = 0;
                    if (din[b] == 2'b11) bad = 1;
                end
                if (!mbusy && cs && n < DEPTH) begin
                    push = 1; mack = 1; mbusy = 1; mcool = 1;
                    if (bad) merr = 1;
                end else if (mcool) begin
                    mcool = 0;
                end else if (mbusy && ns) begin
                    mack = 0; mbusy = 0;
                end
                mv = (n - int'(pop)) > 0;
                if (mv) md = mq[pop ? 1 : 0];
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(word);
                ch = {ch[SYNC-2:0], all_set};
                nh = {nh[SYNC-2:0], all_null};
            end
        end
    end

    // Compare the DUT with the model every cycle, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                check("cyc_ack",   32'(ack_o),   32'(mack));
                check("cyc_valid", 32'(m_valid), 32'(mv));
                check("cyc_level", 32'(level),   32'(mq.size()));
                check("cyc_err",   32'(err_o),   32'(merr));
                if (mv) check("cyc_data", m_data, md);
            end
        end
    end

    // Record every word handed over on the stream.
    logic [31:0] popped[$];
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) popped.push_back(m_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v);
        int k;
        k = 0;
        while (ack_o !== v && k < 40) begin
            tick(1);
            k++;
        end
        checks++;
        if (ack_o !== v) begin
            errors++;
            $display("FAIL wait_ack: ack_o=%0b never reached %0b", ack_o, v);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] bad);
        din = dr(w, bad);
        wait_ack(1'b1);
        din = '0;
        wait_ack(1'b0);
    endtask

    task automatic check_popped(input string name, input logic [31:0] exp[$]);
        check({name, "_count"}, 32'(popped.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            check(name, popped[i], exp[i]);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w;

        // 1 reset
        rst = 1'b1; din = '0; m_ready = 1'b0;
        tick(1);
        rst = 1'b0;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_data", m_data, 32'd0);

        // 2 single word with exact latencies
        din = dr(32'h5, 32'h0);
        tick(2);
        check("t2_ack_early", 32'(ack_o), 32'd0);
        tick(1);
        check("t2_ack_rise", 32'(ack_o), 32'd1);
        tick(1);
        check("t2_valid", 32'(m_valid), 32'd1);
        check("t2_data", m_data, 32'h5);
        din = '0;
        tick(2);
        check("t2_ack_hold", 32'(ack_o), 32'd1);
        tick(1);
        check("t2_ack_fall", 32'(ack_o), 32'd0);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        check("t2_level0", 32'(level), 32'd0);

        // 3 backpressure with a full FIFO
        send(32'd1, 32'd0);
        send(32'd1, 32'd0);
        send(32'd2, 32'd0);
        send(32'd3, 32'd0);
        tick(2);
        check("t3_full", 32'(level), 32'd4);
        din = dr(32'd5, 32'h0);
        tick(10);
        check("t3_blocked_ack", 32'(ack_o), 32'd0);
        check("t3_blocked_level", 32'(level), 32'd4);
        check("t3_head_held", m_data, 32'd1);
        popped.delete();
        m_ready = 1'b1;
        wait_ack(1'b1);
        din = '0;
        wait_ack(1'b0);
        tick(6);
        exp_q = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
        check_popped("t3_order", exp_q);
        check("t3_level0", 32'(level), 32'd0);

        // 4 pointer wrap with continuous draining
        popped.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            w = 32'h1111_1111 * (i + 1) ^ 32'h0000_00A5;
            exp_q.push_back(w);
            send(w, 32'h0);
        end
        tick(6);
        check_popped("t4_wrap", exp_q);
        check("t4_level0", 32'(level), 32'd0);
        m_ready = 1'b0;

        // 5 illegal codeword: bit 3 is 2'b11, every other bit is logic 0
        send(32'h0, 32'h8);
        tick(2);
        check("t5_err", 32'(err_o), 32'd1);
        check("t5_valid", 32'(m_valid), 32'd1);
        check("t5_data", m_data, 32'h8);
        m_ready = 1'b1;
        tick(2);
        send(32'h77, 32'h0);
        tick(3);
        check("t5_err_sticky", 32'(err_o), 32'd1);
        m_ready = 1'b0;

        // 6 reset during WAIT_NULL, then recapture the held word
        din = dr(32'h1234, 32'h0);
        wait_ack(1'b1);
        tick(1);
        check("t6_ack_before", 32'(ack_o), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_ack_rst", 32'(ack_o), 32'd0);
        check("t6_level_rst", 32'(level), 32'd0);
        check("t6_err_rst", 32'(err_o), 32'd0);
        wait_ack(1'b1);
        tick(1);
        check("t6_recap_valid", 32'(m_valid), 32'd1);
        check("t6_recap_data", m_data, 32'h1234);
        din = '0;
        wait_ack(1'b0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
